// File: rtl/ecc_point_double_if.sv
// Request/response bundle between the scalar-multiplication controller and the point doubler.
// The controller drives the operands and start; the doubler returns busy/done and 2P.
interface ecc_point_double_if #(
    parameter int LEN = 256
);
    logic           start;
    logic [LEN-1:0] a;
    logic [LEN-1:0] p;
    logic [LEN-1:0] p_prime;
    logic [LEN-1:0] r2_mod_p;
    logic [LEN-1:0] px;
    logic [LEN-1:0] py;
    logic [LEN-1:0] pz;
    logic           busy;
    logic           done;
    logic [LEN-1:0] rx;
    logic [LEN-1:0] ry;
    logic [LEN-1:0] rz;

    modport master (
        output start, a, p, p_prime, r2_mod_p, px, py, pz,
        input  busy, done, rx, ry, rz
    );

    modport slave (
        input  start, a, p, p_prime, r2_mod_p, px, py, pz,
        output busy, done, rx, ry, rz
    );
endinterface

// File: rtl/ecc_point_double.sv
// Jacobian point doubler over GF(p): one Montgomery multiply or modular add/sub per cycle,
// LATENCY = 30 cycles from start-accept edge to done. Define ECC_PD_INFINITY_EN to force (1,1,0) when py or pz is 0.
module ecc_point_double #(
    parameter int LEN = 256
) (
    input  logic               clk,
    input  logic               rst,
    ecc_point_double_if.slave  bus
);

    localparam int             LATENCY   = 30;
    localparam logic [4:0]     LAST_STEP = 5'(LATENCY - 1);
    localparam logic [LEN-1:0] ONE       = {{(LEN-1){1'b0}}, 1'b1};
    localparam logic [LEN-1:0] ZERO      = {LEN{1'b0}};

    // Register-file slots; XX and YY are reused to stage the converted rx/ry.
    localparam logic [3:0] R_X    = 4'd0;
    localparam logic [3:0] R_Y    = 4'd1;
    localparam logic [3:0] R_Z    = 4'd2;
    localparam logic [3:0] R_A    = 4'd3;
    localparam logic [3:0] R_R2   = 4'd4;
    localparam logic [3:0] R_XX   = 4'd5;
    localparam logic [3:0] R_YY   = 4'd6;
    localparam logic [3:0] R_YYYY = 4'd7;
    localparam logic [3:0] R_ZZ   = 4'd8;
    localparam logic [3:0] R_T    = 4'd9;
    localparam logic [3:0] R_M    = 4'd10;
    localparam logic [3:0] R_S    = 4'd11;
    localparam logic [3:0] R_X3   = 4'd12;
    localparam logic [3:0] R_Y3   = 4'd13;
    localparam logic [3:0] R_Z3   = 4'd14;
    localparam logic [3:0] R_ONE  = 4'd15;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;
    typedef enum logic [1:0] {OP_MM = 2'd0, OP_ADD = 2'd1, OP_SUB = 2'd2} op_t;

    typedef struct packed {
        op_t        kind;
        logic [3:0] dst;
        logic [3:0] sa;
        logic [3:0] sb;
    } uop_t;

    function automatic logic [LEN-1:0] mont_mul(input logic [LEN-1:0] x, input logic [LEN-1:0] y,
                                                input logic [LEN-1:0] n, input logic [LEN-1:0] n_prime);
        logic [2*LEN-1:0] t;
        logic [LEN-1:0]   m;
        logic [2*LEN:0]   s;
        logic [LEN:0]     u;
        t = {{LEN{1'b0}}, x} * {{LEN{1'b0}}, y};
        m = t[LEN-1:0] * n_prime;
        s = {1'b0, t} + ({{(LEN+1){1'b0}}, m} * {{(LEN+1){1'b0}}, n});
        u = (LEN+1)'(s >> LEN);
        if (u >= {1'b0, n}) begin
            u = u - {1'b0, n};
        end else begin
            u = u;
        end
        return u[LEN-1:0];
    endfunction

    function automatic logic [LEN-1:0] mod_addsub(input logic [LEN-1:0] x, input logic [LEN-1:0] y,
                                                  input logic [LEN-1:0] n, input logic sub);
        logic [LEN:0] s;
        if (sub) begin
            s = {1'b0, x} - {1'b0, y};
            if (x < y) begin
                s = s + {1'b0, n};
            end else begin
                s = s;
            end
        end else begin
            s = {1'b0, x} + {1'b0, y};
            if (s >= {1'b0, n}) begin
                s = s - {1'b0, n};
            end else begin
                s = s;
            end
        end
        return LEN'(s);
    endfunction

    // Fixed schedule: domain entry, doubling formulas, domain exit.
    function automatic uop_t uop_rom(input logic [4:0] step);
        uop_t u;
        case (step)
            5'd0:    u = '{OP_MM,  R_X,    R_X,    R_R2};
            5'd1:    u = '{OP_MM,  R_Y,    R_Y,    R_R2};
            5'd2:    u = '{OP_MM,  R_Z,    R_Z,    R_R2};
            5'd3:    u = '{OP_MM,  R_A,    R_A,    R_R2};
            5'd4:    u = '{OP_MM,  R_XX,   R_X,    R_X};
            5'd5:    u = '{OP_MM,  R_YY,   R_Y,    R_Y};
            5'd6:    u = '{OP_MM,  R_YYYY, R_YY,   R_YY};
            5'd7:    u = '{OP_MM,  R_ZZ,   R_Z,    R_Z};
            5'd8:    u = '{OP_MM,  R_ZZ,   R_ZZ,   R_ZZ};
            5'd9:    u = '{OP_MM,  R_T,    R_A,    R_ZZ};
            5'd10:   u = '{OP_ADD, R_M,    R_XX,   R_XX};
            5'd11:   u = '{OP_ADD, R_M,    R_M,    R_XX};
            5'd12:   u = '{OP_ADD, R_M,    R_M,    R_T};
            5'd13:   u = '{OP_MM,  R_S,    R_X,    R_YY};
            5'd14:   u = '{OP_ADD, R_S,    R_S,    R_S};
            5'd15:   u = '{OP_ADD, R_S,    R_S,    R_S};
            5'd16:   u = '{OP_MM,  R_X3,   R_M,    R_M};
            5'd17:   u = '{OP_ADD, R_T,    R_S,    R_S};
            5'd18:   u = '{OP_SUB, R_X3,   R_X3,   R_T};
            5'd19:   u = '{OP_SUB, R_T,    R_S,    R_X3};
            5'd20:   u = '{OP_MM,  R_Y3,   R_M,    R_T};
            5'd21:   u = '{OP_ADD, R_T,    R_YYYY, R_YYYY};
            5'd22:   u = '{OP_ADD, R_T,    R_T,    R_T};
            5'd23:   u = '{OP_ADD, R_T,    R_T,    R_T};
            5'd24:   u = '{OP_SUB, R_Y3,   R_Y3,   R_T};
            5'd25:   u = '{OP_MM,  R_Z3,   R_Y,    R_Z};
            5'd26:   u = '{OP_ADD, R_Z3,   R_Z3,   R_Z3};
            5'd27:   u = '{OP_MM,  R_XX,   R_X3,   R_ONE};
            5'd28:   u = '{OP_MM,  R_YY,   R_Y3,   R_ONE};
            5'd29:   u = '{OP_MM,  R_Z3,   R_Z3,   R_ONE};
            default: u = '{OP_MM,  R_T,    R_ONE,  R_ONE};
        endcase
        return u;
    endfunction

    state_t         state_r;
    state_t         state_nx;
    logic           accept_s;
    logic           last_s;
    logic [4:0]     step_r;
    logic [LEN-1:0] rf_r [0:15];
    logic [LEN-1:0] p_r;
    logic [LEN-1:0] pp_r;
    uop_t           uop_s;
    logic [LEN-1:0] opa_s;
    logic [LEN-1:0] opb_s;
    logic [LEN-1:0] res_s;
    logic           busy_r;
    logic           done_r;
    logic [LEN-1:0] rx_r;
    logic [LEN-1:0] ry_r;
    logic [LEN-1:0] rz_r;
    logic [LEN-1:0] rx_nx;
    logic [LEN-1:0] ry_nx;
    logic [LEN-1:0] rz_nx;
`ifdef ECC_PD_INFINITY_EN
    logic           inf_r;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state; start during the done cycle is not accepted.
    always_comb begin
        state_nx = state_r;
        accept_s = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start && !done_r) begin
                    state_nx = RUN;
                    accept_s = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (step_r == LAST_STEP) begin
                    state_nx = IDLE;
                    last_s   = 1'b1;
                end else begin
                    state_nx = RUN;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand fetch and the shared arithmetic units.
    always_comb begin
        res_s = ZERO;
        uop_s = uop_rom(step_r);
        opa_s = rf_r[uop_s.sa];
        opb_s = rf_r[uop_s.sb];
        case (uop_s.kind)
            OP_MM:   res_s = mont_mul(opa_s, opb_s, p_r, pp_r);
            OP_ADD:  res_s = mod_addsub(opa_s, opb_s, p_r, 1'b0);
            OP_SUB:  res_s = mod_addsub(opa_s, opb_s, p_r, 1'b1);
            default: res_s = ZERO;
        endcase
    end

    // Result selection on the final op.
    always_comb begin
        rx_nx = rf_r[R_XX];
        ry_nx = rf_r[R_YY];
        rz_nx = res_s;
`ifdef ECC_PD_INFINITY_EN
        if (inf_r) begin
            rx_nx = ONE;
            ry_nx = ONE;
            rz_nx = ZERO;
        end else begin
            rx_nx = rf_r[R_XX];
            ry_nx = rf_r[R_YY];
            rz_nx = res_s;
        end
`endif
    end

    // Operand capture, micro-op execution and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                rf_r[i] <= ZERO;
            end
            p_r    <= ZERO;
            pp_r   <= ZERO;
            step_r <= 5'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            rx_r   <= ZERO;
            ry_r   <= ZERO;
            rz_r   <= ZERO;
`ifdef ECC_PD_INFINITY_EN
            inf_r  <= 1'b0;
`endif
        end else begin
            if (accept_s) begin
                rf_r[R_X]   <= bus.px;
                rf_r[R_Y]   <= bus.py;
                rf_r[R_Z]   <= bus.pz;
                rf_r[R_A]   <= bus.a;
                rf_r[R_R2]  <= bus.r2_mod_p;
                rf_r[R_ONE] <= ONE;
                p_r         <= bus.p;
                pp_r        <= bus.p_prime;
                step_r      <= 5'd0;
`ifdef ECC_PD_INFINITY_EN
                inf_r       <= (bus.py == ZERO) || (bus.pz == ZERO);
`endif
            end else if (state_r == RUN) begin
                rf_r[uop_s.dst] <= res_s;
                step_r          <= last_s ? 5'd0 : step_r + 5'd1;
            end else begin
                step_r <= step_r;
            end
            busy_r <= (state_r == RUN) && !last_s;
            done_r <= last_s;
            if (last_s) begin
                rx_r <= rx_nx;
                ry_r <= ry_nx;
                rz_r <= rz_nx;
            end else begin
                rx_r <= rx_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.rx   = rx_r;
    assign bus.ry   = ry_r;
    assign bus.rz   = rz_r;

endmodule

// File: tb/tb_ecc_point_double.sv
// Self-checking bench for ecc_point_double: P-256 known answer, random points against a
// plain modular-arithmetic model of the doubling formulas, protocol, reset and latency checks.
module tb_ecc_point_double;

    localparam int LEN = 256;
    localparam int N   = 30;

    localparam logic [255:0] P256_P  = 256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
    localparam logic [255:0] P256_A  = 256'hffffffff00000001000000000000000000000000fffffffffffffffffffffffc;
    localparam logic [255:0] P256_PP = 256'hffffffff00000002000000000000000000000001000000000000000000000001;
    localparam logic [255:0] P256_R2 = 256'h4fffffffdfffffffffffffffefffffffbffffffff0000000000000003;
    localparam logic [255:0] GX  = 256'h6b17d1f2e12c4247f8bce6e563a440f277037d812deb33a0f4a13945d898c296;
    localparam logic [255:0] GY  = 256'h4fe342e2fe1a7f9b8ee7eb4a7c0f9e162bce33576b315ececbb6406837bf51f5;
    localparam logic [255:0] G2X = 256'h9a978f59acd1b5ad570e7d52dcfcde43804b42274f61ddcf1e7d848391d6c70f;
    localparam logic [255:0] G2Y = 256'h4126885e7f786af905338238e5346d5fe77fc46388668bd0fd59be3190d2f5d1;
    localparam logic [255:0] G2Z = 256'h9fc685c5fc34ff371dcfd694f81f3c2c579c66aed662bd9d976c80d06f7ea3ea;
    localparam logic [255:0] Z256 = 256'd0;
    localparam logic [255:0] O256 = 256'd1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ecc_point_double_if #(.LEN(LEN)) bus ();

    ecc_point_double #(.LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] fmul(input logic [255:0] x, input logic [255:0] y, input logic [255:0] m);
        logic [511:0] t;
        t = {256'd0, x} * {256'd0, y};
        t = t % {256'd0, m};
        return t[255:0];
    endfunction

    function automatic logic [255:0] fadd(input logic [255:0] x, input logic [255:0] y, input logic [255:0] m);
        logic [256:0] s;
        s = {1'b0, x} + {1'b0, y};
        s = s % {1'b0, m};
        return s[255:0];
    endfunction

    function automatic logic [255:0] fsub(input logic [255:0] x, input logic [255:0] y, input logic [255:0] m);
        return fadd(x, m - y, m);
    endfunction

    function automatic logic [255:0] rnd_mod(input logic [255:0] m);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = $urandom;
        end
        return fmul(r, O256, m);
    endfunction

    // 2P from the textbook Jacobian formulas, computed directly in normal form mod p.
    task automatic model_double(input logic [255:0] ia, input logic [255:0] ix, input logic [255:0] iy,
                                input logic [255:0] iz, input logic [255:0] m,
                                output logic [255:0] ox, output logic [255:0] oy, output logic [255:0] oz);
        logic [255:0] xx, yy, yyyy, zz, zzzz, mm, s;
        xx   = fmul(ix, ix, m);
        yy   = fmul(iy, iy, m);
        yyyy = fmul(yy, yy, m);
        zz   = fmul(iz, iz, m);
        zzzz = fmul(zz, zz, m);
        mm   = fadd(fmul(256'd3, xx, m), fmul(ia, zzzz, m), m);
        s    = fmul(256'd4, fmul(ix, yy, m), m);
        ox   = fsub(fmul(mm, mm, m), fmul(256'd2, s, m), m);
        oy   = fsub(fmul(mm, fsub(s, ox, m), m), fmul(256'd8, yyyy, m), m);
        oz   = fmul(256'd2, fmul(iy, iz, m), m);
    endtask

    task automatic drive(input logic [255:0] ia, input logic [255:0] ix, input logic [255:0] iy, input logic [255:0] iz);
        bus.a        = ia;
        bus.p        = P256_P;
        bus.p_prime  = P256_PP;
        bus.r2_mod_p = P256_R2;
        bus.px       = ix;
        bus.py       = iy;
        bus.pz       = iz;
    endtask

    // One complete operation; lat = edges from accept to done (0 if it never came).
    task automatic run_double(input logic [255:0] ia, input logic [255:0] ix, input logic [255:0] iy,
                              input logic [255:0] iz, output int lat, output int bcnt);
        @(negedge clk);
        drive(ia, ix, iy, iz);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 0;
        bcnt = bus.busy ? 1 : 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                break;
            end
            if (bus.busy) bcnt++;
        end
    endtask

    task automatic check_point(input string tag, input logic [255:0] ex, input logic [255:0] ey, input logic [255:0] ez);
        check_val({tag, ".rx"}, bus.rx, ex);
        check_val({tag, ".ry"}, bus.ry, ey);
        check_val({tag, ".rz"}, bus.rz, ez);
    endtask

    initial begin
        int lat, bcnt, ndone, dcyc, busy_late;
        logic [255:0] cx, cy, cz, ra, rxv, ryv, rzv, ex, ey, ez;

        rst       = 1'b1;
        bus.start = 1'b0;
        drive(P256_A, GX, GY, O256);
        #12;
        check_val("reset.busy", {255'd0, bus.busy}, Z256);
        check_val("reset.done", {255'd0, bus.done}, Z256);
        check_point("reset", Z256, Z256, Z256);
        @(negedge clk);
        rst = 1'b0;

        // Generator doubling.
        run_double(P256_A, GX, GY, O256, lat, bcnt);
        check_val("g2.latency", 256'(lat), 256'(N));
        check_val("g2.busy_cycles", 256'(bcnt), 256'(N - 1));
        check_point("g2", G2X, G2Y, G2Z);

        // Start re-pulsed while busy with changed inputs, and again in the done cycle.
        @(negedge clk);
        drive(P256_A, GX, GY, O256);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0; dcyc = 0; busy_late = 0;
        cx = Z256; cy = Z256; cz = Z256;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (c == 5) begin
                drive(rnd_mod(P256_P), rnd_mod(P256_P), rnd_mod(P256_P), rnd_mod(P256_P));
                bus.start = 1'b1;
            end
            if (c == 12) bus.start = 1'b1;
            if (bus.done) begin
                ndone++;
                dcyc = c;
                cx = bus.rx; cy = bus.ry; cz = bus.rz;
                bus.start = 1'b1;
            end
            if (dcyc != 0 && c == dcyc + 2 && bus.busy) busy_late = 1;
        end
        check_val("restart.done_count", 256'(ndone), O256);
        check_val("restart.latency", 256'(dcyc), 256'(N));
        check_val("restart.rx", cx, G2X);
        check_val("restart.ry", cy, G2Y);
        check_val("restart.rz", cz, G2Z);
        check_val("restart.start_in_done_cycle", 256'(busy_late), Z256);
        run_double(P256_A, GX, GY, O256, lat, bcnt);
        check_val("after_restart.latency", 256'(lat), 256'(N));
        check_point("after_restart", G2X, G2Y, G2Z);

        // Z = 0 input.
        run_double(P256_A, GX, GY, Z256, lat, bcnt);
        check_val("pz0.latency", 256'(lat), 256'(N));
`ifdef ECC_PD_INFINITY_EN
        check_point("pz0", O256, O256, Z256);
`else
        model_double(P256_A, GX, GY, Z256, P256_P, ex, ey, ez);
        check_val("pz0.model_rz", ez, Z256);
        check_point("pz0", ex, ey, Z256);
`endif

        // Asynchronous reset mid-run.
        @(negedge clk);
        drive(P256_A, GX, GY, O256);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst.busy", {255'd0, bus.busy}, Z256);
        check_val("midrst.done", {255'd0, bus.done}, Z256);
        check_point("midrst", Z256, Z256, Z256);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check_val("midrst.no_done", 256'(ndone), Z256);
        run_double(P256_A, GX, GY, O256, lat, bcnt);
        check_val("postrst.latency", 256'(lat), 256'(N));
        check_point("postrst", G2X, G2Y, G2Z);

        // Random points and curve coefficients against the model.
        for (int k = 0; k < 6; k++) begin
            ra  = rnd_mod(P256_P);
            rxv = rnd_mod(P256_P);
            ryv = rnd_mod(P256_P);
            rzv = rnd_mod(P256_P);
            model_double(ra, rxv, ryv, rzv, P256_P, ex, ey, ez);
            run_double(ra, rxv, ryv, rzv, lat, bcnt);
            check_val($sformatf("rand%0d.latency", k), 256'(lat), 256'(N));
            check_val($sformatf("rand%0d.busy_cycles", k), 256'(bcnt), 256'(N - 1));
            check_point($sformatf("rand%0d", k), ex, ey, ez);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
